// File: rtl/div_unit.sv
// div_unit: sequential signed divider (MIPS div semantics), start/stop handshake responder.
// Latency: stop_div and results valid WIDTH+1 cycles after the accepted start edge; divide-by-zero answers after 1 cycle.
// Backpressure: none; start_div is ignored while busy, and results hold until the next completion or reset.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   a_in, b_in          dividend / divisor (two's complement), sampled only when a start is accepted
//   start_div           request, level-sampled on each edge while idle
//   busy                high while a divide is iterating or being sign-corrected
//   stop_div, div_zero  one-cycle done pulse; div_zero accompanies it when the divisor was zero
//   hi_out, lo_out      remainder / quotient registers
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start_div,
  output logic             busy,
  output logic             stop_div,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] quot;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvsr;     // divisor magnitude
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;

  // Magnitudes are unsigned, so the most negative value maps onto itself correctly.
  assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

  // One extra bit: the shifted remainder can reach 2*divisor-1, and the
  // trial difference lies in [-2^WIDTH, 2^WIDTH), so its top bit is the sign.
  assign shifted  = {rem, quot[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvsr};
  assign trial_ok = ~trial[WIDTH];

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      quot     <= '0;
      dvsr     <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      stop_div <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      stop_div <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_div) begin
            if (b_in == '0) begin
              // Answer immediately; result registers keep their previous values.
              stop_div <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              quot   <= a_mag;
              dvsr   <= b_mag;
              rem    <= '0;
              cnt    <= '0;
              sign_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              sign_r <= a_in[WIDTH-1];
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          quot <= {quot[WIDTH-2:0], trial_ok};
          rem  <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          lo_out   <= sign_q ? (~quot + 1'b1) : quot;
          hi_out   <= sign_r ? (~rem + 1'b1) : rem;
          stop_div <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit against a magnitude-arithmetic reference model.
// Latency: checks the 33-cycle done latency, busy window and single-cycle stop/div_zero pulses.
// Backpressure: exercises ignored re-starts while busy and reset aborting an operation.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         start_div;
  logic         busy;
  logic         stop_div;
  logic         div_zero;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .start_div(start_div),
    .busy     (busy),
    .stop_div (stop_div),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: MIPS div from unsigned magnitudes; quotient truncates toward
  // zero, remainder carries the dividend's sign.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    logic [W-1:0] ma, mb, uq, ur;
    z = (b == 0);
    if (z) begin
      q = last_lo;
      r = last_hi;
    end else begin
      ma = a[W-1] ? (0 - a) : a;
      mb = b[W-1] ? (0 - b) : b;
      uq = ma / mb;
      ur = ma % mb;
      q  = (a[W-1] != b[W-1]) ? (0 - uq) : uq;
      r  = a[W-1] ? (0 - ur) : ur;
    end
  endtask

  // Issue one divide and check latency, busy window, pulse width and results.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    bit           ez;
    int           lat, nb;
    model(a, b, eq, er, ez);
    @(negedge clk);
    a_in = a; b_in = b; start_div = 1'b1;
    @(posedge clk);                      // E0
    @(negedge clk);
    start_div = 1'b0;
    a_in = $urandom; b_in = $urandom;    // late operand changes must not matter
    lat = -1; nb = 0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (stop_div) begin lat = k; break; end
      if (busy) nb++;
    end
    if (ez) begin
      chk("dz_latency", lat, 0);
      chk("dz_busy", {31'b0, busy}, 0);
    end else begin
      chk("latency", lat, 33);
      chk("busy_cycles", nb, 33);
    end
    chk("div_zero", {31'b0, div_zero}, {31'b0, ez});
    chk("lo_out", lo_out, eq);
    chk("hi_out", hi_out, er);
    @(negedge clk);
    chk("stop_clear", {31'b0, stop_div}, 0);
    last_lo = eq;
    last_hi = er;
  endtask

  initial begin
    int stops;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start_div = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_stop", {31'b0, stop_div}, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    reset = 1'b0;

    // Directed cases.
    run_op(100, 7);
    run_op(-7, 2);
    run_op(7, -2);
    run_op(5, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(0, 9);
    run_op(32'h8000_0000, 32'h8000_0000);
    run_op(32'h7FFF_FFFF, 1);

    // Reset sampled at E10 aborts the divide with no stop pulse.
    @(negedge clk);
    a_in = 100; b_in = 7; start_div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_div = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_stop", {31'b0, stop_div}, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    reset = 1'b0;
    last_hi = '0; last_lo = '0;
    stops = 0;
    repeat (40) begin @(negedge clk); if (stop_div) stops++; end
    chk("abort_no_stop", stops, 0);
    run_op(100, 7);

    // Re-pulsed start while busy is ignored.
    @(negedge clk);
    a_in = 100; b_in = 7; start_div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_div = 1'b0;
    stops = 0;
    for (int k = 1; k < 70; k++) begin
      @(negedge clk);
      if (k == 5) begin a_in = 3; b_in = 1; start_div = 1'b1; end
      else start_div = 1'b0;
      if (stop_div) stops++;
    end
    chk("repulse_stops", stops, 1);
    chk("repulse_lo", lo_out, 14);
    chk("repulse_hi", hi_out, 2);
    last_lo = 14; last_hi = 2;

    // Randomized operands, including small divisors and occasional zero.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 0;
        1: rb = $urandom_range(1, 15);
        2: rb = 0 - $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      run_op(ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32-bit divider. Responder side of the CPU's start/stop multi-cycle handshake, the same handshake used by the multiplier.
- The control unit pulses start_div with operands from A/B; the block iterates and pulses stop_div when hi_out/lo_out are valid.
- lo_out (quotient) and hi_out (remainder) feed the HI/LO register muxes.
- Restoring shift-subtract on magnitudes, one quotient bit per cycle, then sign correction.

Parameters:
WIDTH, 32, operand/result width; latency scales as WIDTH+1 cycles

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
a_in  input  WIDTH  dividend (two's complement), sampled only when a start is accepted
b_in  input  WIDTH  divisor (two's complement), sampled only when a start is accepted
start_div  input  1  request; level-sampled each edge while IDLE
busy  output  1  high while in RUN or FIX
stop_div  output  1  one-cycle done pulse
div_zero  output  1  one-cycle pulse, coincident with stop_div, when divisor was zero
hi_out  output  WIDTH  remainder register
lo_out  output  WIDTH  quotient register

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high. All state changes on the rising edge of clk only.
- Reset:
  - State goes to IDLE.
  - hi_out=0, lo_out=0, stop_div=0, div_zero=0, busy=0.
  - Iteration counter and internal registers cleared.
  - Reset wins over every other event, including mid-operation: the divide is aborted, no stop_div is issued, and hi_out/lo_out read 0.
- States: IDLE, RUN, FIX.
- IDLE, start_div=1, b_in!=0 at edge E0:
  - Latch |a_in|, |b_in| as unsigned WIDTH-bit magnitudes; |0x80000000| = 0x80000000.
  - Latch sign_q = a[msb]^b[msb] and sign_r = a[msb].
  - Clear partial remainder; counter=0; go to RUN; busy=1.
- IDLE, start_div=1, b_in==0 at E0:
  - Remain IDLE.
  - stop_div=1 and div_zero=1 for exactly one cycle (set at E0, cleared at E1).
  - hi_out/lo_out unchanged.
- RUN:
  - Each edge: shift {rem,quot} left 1 bringing in dividend msb; trial = rem - divisor.
  - If trial is non-negative, rem=trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - Counter increments. After WIDTH iterations (edge E32 for WIDTH=32) go to FIX.
- FIX, at edge E33:
  - lo_out = sign_q ? -quot : quot.
  - hi_out = sign_r ? -rem : rem, all mod 2^WIDTH.
  - stop_div=1 for one cycle; go to IDLE; busy=0.
  - stop_div clears at E34.
- Latency: results valid and stop_div high in the cycle after E(WIDTH+1), i.e. 33 cycles after the start edge.
- Semantics: MIPS div. Quotient truncates toward zero; remainder takes the dividend's sign; |rem| < |divisor|.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0, no flag.
- start_div while busy: ignored. Operands are not resampled, and no second stop_div is issued.
- start_div held high in IDLE after completion: a new divide is accepted on the first IDLE edge, back-to-back. The control unit must deassert start_div to avoid re-triggering.
- hi_out/lo_out hold their last results indefinitely; they change only at FIX or reset.
- Operand changes after the start edge have no effect.

Test Plan:
- 100 / 7: start at E0 -> busy high E0..E33; stop_div high only in cycle after E33; lo_out=14, hi_out=2, div_zero=0.
- -7 / 2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Also 7 / -2 -> lo_out=0xFFFFFFFD, hi_out=1.
- 5 / 0 -> stop_div=1 and div_zero=1 in the single cycle after E0; busy stays 0; prior hi_out/lo_out unchanged.
- 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0. Also 0 / 9 -> lo_out=0, hi_out=0.
- Reset during RUN at E10 -> busy, stop_div and hi/lo all 0 next cycle, and no stop_div ever appears for that op. A subsequent 100/7 completes correctly with 33-cycle latency.
- start_div re-pulsed at E5 with different operands during 100/7 -> ignored; exactly one stop_div pulse, with lo_out=14 and hi_out=2.
